// File: rtl/axi_sram_slave.sv
`timescale 1ns/1ps
// AXI3 slave in front of a word-addressed 32-bit on-chip array.
// Independent read and write FSMs, each holding one outstanding burst (INCR/FIXED, up to 16 beats).
module axi_sram_slave #(
   parameter int ADDR_W = 16,
   parameter int ID_W   = 4
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [ID_W-1:0]   arid,
   input  logic [31:0]       araddr,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [1:0]        arburst,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   input  logic [ID_W-1:0]   awid,
   input  logic [31:0]       awaddr,
   input  logic [7:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic [1:0]        awburst,
   input  logic              awvalid,
   output logic              awready,
   input  logic [ID_W-1:0]   wid,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready
);

   localparam int         DEPTH  = 1 << (ADDR_W - 2);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_ACC, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

   // FIXED holds the address; INCR and WRAP both step by the beat size with no wrap boundary.
   function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [2:0] size,
                                               input logic [1:0] burst);
      if (burst == 2'b00) return addr;
      return addr + (32'd1 << size);
   endfunction

   function automatic logic f_addr_err(input logic [31:0] addr, input logic [2:0] size,
                                       input logic [1:0] burst);
      return (size > 3'd2) || (burst == 2'b11) || (addr[31:ADDR_W] != '0);
   endfunction

   logic [31:0]       r_mem [0:DEPTH-1];

   rstate_t           r_rstate, w_rnext;
   logic [ID_W-1:0]   r_arid;
   logic [31:0]       r_araddr;
   logic [7:0]        r_arlen, r_rbeat;
   logic [2:0]        r_arsize;
   logic [1:0]        r_arburst;
   logic [31:0]       r_rdata;
   logic [1:0]        r_rresp;
   logic              w_ar_hs, w_r_hs, w_rlast_beat, w_rerr;
   logic [ADDR_W-3:0] w_ridx;

   wstate_t           r_wstate, w_wnext;
   logic [ID_W-1:0]   r_awid;
   logic [31:0]       r_awaddr;
   logic [7:0]        r_awlen, r_wbeat;
   logic [2:0]        r_awsize;
   logic [1:0]        r_awburst;
   logic              r_werr;
   logic              w_aw_hs, w_w_hs, w_wlast_beat, w_werr, w_we;
   logic [ADDR_W-3:0] w_widx;

   assign w_ar_hs      = (r_rstate == R_IDLE) && arvalid;
   assign w_r_hs       = (r_rstate == R_DATA) && rready;
   assign w_rlast_beat = (r_rbeat == r_arlen);
   assign w_rerr       = f_addr_err(r_araddr, r_arsize, r_arburst);
   assign w_ridx       = r_araddr[ADDR_W-1:2];

   always_ff @(posedge aclk) begin
      if (!aresetn) r_rstate <= R_IDLE;
      else          r_rstate <= w_rnext;
   end

   always_comb begin
      w_rnext = r_rstate;
      case (r_rstate)
         R_IDLE:  if (arvalid) w_rnext = R_ACC;
         R_ACC:   w_rnext = R_DATA;
         R_DATA:  if (rready) w_rnext = w_rlast_beat ? R_IDLE : R_ACC;
         default: w_rnext = R_IDLE;
      endcase
   end

   always_comb begin
      arready = (r_rstate == R_IDLE);
      rvalid  = (r_rstate == R_DATA);
      rlast   = (r_rstate == R_DATA) && w_rlast_beat;
   end

   // rdata only changes in R_ACC, so it is naturally held while the master stalls
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_arid  <= '0;
         r_rdata <= '0;
         r_rresp <= OKAY;
      end else begin
         if (w_ar_hs) r_arid <= arid;
         if (r_rstate == R_ACC) begin
            r_rdata <= w_rerr ? 32'd0 : r_mem[w_ridx];
            r_rresp <= w_rerr ? SLVERR : OKAY;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (w_ar_hs) begin
         r_araddr  <= araddr;
         r_arlen   <= arlen;
         r_arsize  <= arsize;
         r_arburst <= arburst;
         r_rbeat   <= 8'd0;
      end else if (w_r_hs && !w_rlast_beat) begin
         r_araddr <= f_next_addr(r_araddr, r_arsize, r_arburst);
         r_rbeat  <= r_rbeat + 8'd1;
      end
   end

   assign rid   = r_arid;
   assign rdata = r_rdata;
   assign rresp = r_rresp;

   assign w_aw_hs      = (r_wstate == W_IDLE) && awvalid;
   assign w_w_hs       = (r_wstate == W_DATA) && wvalid;
   assign w_wlast_beat = (r_wbeat == r_awlen);
   assign w_werr       = f_addr_err(r_awaddr, r_awsize, r_awburst) || (wid != r_awid) ||
                         (wlast != w_wlast_beat);
   assign w_we         = w_w_hs && !w_werr;
   assign w_widx       = r_awaddr[ADDR_W-1:2];

   always_ff @(posedge aclk) begin
      if (!aresetn) r_wstate <= W_IDLE;
      else          r_wstate <= w_wnext;
   end

   always_comb begin
      w_wnext = r_wstate;
      case (r_wstate)
         W_IDLE:  if (awvalid) w_wnext = W_DATA;
         W_DATA:  if (wvalid && w_wlast_beat) w_wnext = W_RESP;
         W_RESP:  if (bready) w_wnext = W_IDLE;
         default: w_wnext = W_IDLE;
      endcase
   end

   always_comb begin
      awready = (r_wstate == W_IDLE);
      wready  = (r_wstate == W_DATA);
      bvalid  = (r_wstate == W_RESP);
      bresp   = ((r_wstate == W_RESP) && r_werr) ? SLVERR : OKAY;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_awid <= '0;
         r_werr <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_awid <= awid;
            r_werr <= 1'b0;
         end else if (w_w_hs && w_werr) begin
            r_werr <= 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (w_aw_hs) begin
         r_awaddr  <= awaddr;
         r_awlen   <= awlen;
         r_awsize  <= awsize;
         r_awburst <= awburst;
         r_wbeat   <= 8'd0;
      end else if (w_w_hs) begin
         r_awaddr <= f_next_addr(r_awaddr, r_awsize, r_awburst);
         r_wbeat  <= r_wbeat + 8'd1;
      end
   end

   assign bid = r_awid;

   // Array is never reset; a same-edge R_ACC read sees the pre-write word
   always_ff @(posedge aclk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
// Directed bench for axi_sram_slave: one task per scenario, inline comparisons.
module tb_axi_sram_slave;
   localparam int ADDR_W = 16;
   localparam int ID_W   = 4;
   localparam int TMO    = 50;

   logic            aclk = 1'b0, aresetn = 1'b0;
   logic [ID_W-1:0] arid = '0, awid = '0, wid = '0;
   logic [31:0]     araddr = '0, awaddr = '0, wdata = '0;
   logic [7:0]      arlen = '0, awlen = '0;
   logic [2:0]      arsize = '0, awsize = '0;
   logic [1:0]      arburst = '0, awburst = '0;
   logic            arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
   logic            rready = 1'b0, bready = 1'b0;
   logic [3:0]      wstrb = '0;
   logic            arready, awready, wready, rvalid, rlast, bvalid;
   logic [ID_W-1:0] rid, bid;
   logic [31:0]     rdata;
   logic [1:0]      rresp, bresp;

   int checks = 0, failures = 0;

   always #5 aclk = ~aclk;

   axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic tick();
      @(posedge aclk); #1;
   endtask

   task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      while (!arready && n < TMO) begin tick(); n++; end
      tick();
      arvalid = 1'b0;
   endtask

   task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      while (!awready && n < TMO) begin tick(); n++; end
      tick();
      awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                         input logic [ID_W-1:0] id);
      int n = 0;
      wdata = d; wstrb = s; wlast = l; wid = id; wvalid = 1'b1;
      while (!wready && n < TMO) begin tick(); n++; end
      tick();
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   // Timeouts return X so the caller's comparison fails
   task automatic rd_beat(output logic [31:0] d, output logic [1:0] r, output logic [ID_W-1:0] id,
                          output logic l);
      int n = 0;
      rready = 1'b1;
      while (!rvalid && n < TMO) begin tick(); n++; end
      if (rvalid) begin d = rdata; r = rresp; id = rid; l = rlast; end
      else begin d = 'x; r = 'x; id = 'x; l = 1'bx; end
      tick();
      rready = 1'b0;
   endtask

   task automatic b_get(output logic [ID_W-1:0] id, output logic [1:0] r);
      int n = 0;
      bready = 1'b1;
      while (!bvalid && n < TMO) begin tick(); n++; end
      if (bvalid) begin id = bid; r = bresp; end
      else begin id = 'x; r = 'x; end
      tick();
      bready = 1'b0;
   endtask

   task automatic wr1(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r);
      logic [ID_W-1:0] id;
      aw_send(4'd1, addr, 8'd0, 3'd2, 2'b01);
      w_beat(d, s, 1'b1, 4'd1);
      b_get(id, r);
   endtask

   task automatic rd1(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
      logic [ID_W-1:0] id;
      logic l;
      ar_send(4'd0, addr, 8'd0, 3'd2, 2'b01);
      rd_beat(d, r, id, l);
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      tick(); tick();
      checks++;
      if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b110000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=110000", {arready, awready, wready, rvalid, bvalid, rlast});
      end
      checks++;
      if ({rdata, rid, rresp, bid, bresp} !== '0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {rdata, rid, rresp, bid, bresp});
      end
      aresetn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [ID_W-1:0] id;
      logic [1:0] r;
      aw_send(4'd1, 32'h10, 8'd0, 3'd2, 2'b01);
      w_beat(32'hDEADBEEF, 4'hF, 1'b1, 4'd1);
      b_get(id, r);
      checks++;
      if ({id, r} !== {4'd1, 2'b00}) begin
         failures++; $display("FAIL single_b got=%h/%b exp=1/00", id, r);
      end
      ar_send(4'd0, 32'h10, 8'd0, 3'd2, 2'b01);
      checks++;
      if (rvalid !== 1'b0) begin failures++; $display("FAIL single_early_rvalid got=%b exp=0", rvalid); end
      tick();
      checks++;
      if ({rvalid, rdata, rid, rlast, rresp} !== {1'b1, 32'hDEADBEEF, 4'd0, 1'b1, 2'b00}) begin
         failures++;
         $display("FAIL single_r got=%b %h %h %b %b exp=1 deadbeef 0 1 00", rvalid, rdata, rid, rlast, rresp);
      end
      rready = 1'b1; tick(); rready = 1'b0;
      checks++;
      if (rvalid !== 1'b0) begin failures++; $display("FAIL single_r_done got=%b exp=0", rvalid); end
   endtask

   task automatic test_strobes();
      logic [1:0] r;
      logic [31:0] d;
      wr1(32'h30, 32'h0, 4'hF, r);
      wr1(32'h30, 32'h11223344, 4'b0101, r);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL strb_bresp got=%b exp=00", r); end
      rd1(32'h30, d, r);
      checks++;
      if (d !== 32'h00220044) begin failures++; $display("FAIL strb_rdata got=%h exp=00220044", d); end
   endtask

   task automatic test_incr_burst();
      logic [ID_W-1:0] id;
      logic [1:0] r;
      logic [31:0] d;
      logic l;
      int n = 0;
      aw_send(4'd2, 32'h20, 8'd3, 3'd2, 2'b01);
      w_beat(32'd1, 4'hF, 1'b0, 4'd2);
      w_beat(32'd2, 4'hF, 1'b0, 4'd2);
      w_beat(32'd3, 4'hF, 1'b0, 4'd2);
      w_beat(32'd4, 4'hF, 1'b1, 4'd2);
      b_get(id, r);
      checks++;
      if ({id, r} !== {4'd2, 2'b00}) begin failures++; $display("FAIL burst_b got=%h/%b exp=2/00", id, r); end
      ar_send(4'd5, 32'h20, 8'd3, 3'd2, 2'b01);
      rd_beat(d, r, id, l);
      checks++;
      if ({d, id, l} !== {32'd1, 4'd5, 1'b0}) begin
         failures++; $display("FAIL burst_beat1 got=%h %h %b exp=1 5 0", d, id, l);
      end
      while (!rvalid && n < TMO) begin tick(); n++; end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({rvalid, rdata} !== {1'b1, 32'd2}) begin
            failures++; $display("FAIL burst_hold%0d got=%b %h exp=1 2", i, rvalid, rdata);
         end
         tick();
      end
      rd_beat(d, r, id, l);
      checks++;
      if ({d, l} !== {32'd2, 1'b0}) begin failures++; $display("FAIL burst_beat2 got=%h %b exp=2 0", d, l); end
      rd_beat(d, r, id, l);
      checks++;
      if ({d, l} !== {32'd3, 1'b0}) begin failures++; $display("FAIL burst_beat3 got=%h %b exp=3 0", d, l); end
      rd_beat(d, r, id, l);
      checks++;
      if ({d, l, r} !== {32'd4, 1'b1, 2'b00}) begin
         failures++; $display("FAIL burst_beat4 got=%h %b %b exp=4 1 00", d, l, r);
      end
   endtask

   task automatic test_errors();
      logic [ID_W-1:0] id;
      logic [1:0] r;
      logic [31:0] d;
      logic l;
      wr1(32'h0, 32'hCAFEF00D, 4'hF, r);
      ar_send(4'd3, 32'h00010000, 8'd0, 3'd2, 2'b01);
      rd_beat(d, r, id, l);
      checks++;
      if ({d, r, l} !== {32'd0, 2'b10, 1'b1}) begin
         failures++; $display("FAIL err_rd_range got=%h %b %b exp=0 10 1", d, r, l);
      end
      wr1(32'h40, 32'h0BADC0DE, 4'hF, r);
      aw_send(4'd1, 32'h40, 8'd1, 3'd2, 2'b01);
      w_beat(32'h55555555, 4'hF, 1'b1, 4'd1);
      w_beat(32'h66666666, 4'hF, 1'b1, 4'd1);
      b_get(id, r);
      checks++;
      if (r !== 2'b10) begin failures++; $display("FAIL err_wlast_bresp got=%b exp=10", r); end
      rd1(32'h40, d, r);
      checks++;
      if (d !== 32'h0BADC0DE) begin failures++; $display("FAIL err_wlast_beat0 got=%h exp=0badc0de", d); end
      rd1(32'h44, d, r);
      checks++;
      if (d !== 32'h66666666) begin failures++; $display("FAIL err_wlast_beat1 got=%h exp=66666666", d); end
      wr1(32'h50, 32'hA5A5A5A5, 4'hF, r);
      aw_send(4'd1, 32'h50, 8'd0, 3'd2, 2'b11);
      w_beat(32'h12345678, 4'hF, 1'b1, 4'd1);
      b_get(id, r);
      checks++;
      if (r !== 2'b10) begin failures++; $display("FAIL err_awburst_bresp got=%b exp=10", r); end
      rd1(32'h50, d, r);
      checks++;
      if (d !== 32'hA5A5A5A5) begin failures++; $display("FAIL err_awburst_mem got=%h exp=a5a5a5a5", d); end
      ar_send(4'd0, 32'h50, 8'd0, 3'd2, 2'b11);
      rd_beat(d, r, id, l);
      checks++;
      if ({d, r} !== {32'd0, 2'b10}) begin failures++; $display("FAIL err_arburst got=%h %b exp=0 10", d, r); end
      wr1(32'h54, 32'h1, 4'hF, r);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL err_flag_cleared got=%b exp=00", r); end
   endtask

   task automatic test_concurrent();
      logic [ID_W-1:0] id;
      logic [1:0] r;
      logic [31:0] d;
      logic l;
      wr1(32'h60, 32'h11111111, 4'hF, r);
      checks++;
      if ({arready, awready} !== 2'b11) begin failures++; $display("FAIL conc_ready got=%b exp=11", {arready, awready}); end
      arid = 4'd4; araddr = 32'h60; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
      awid = 4'd6; awaddr = 32'h70; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
      arvalid = 1'b1; awvalid = 1'b1;
      tick();
      arvalid = 1'b0; awvalid = 1'b0;
      w_beat(32'h77777777, 4'hF, 1'b1, 4'd6);
      rd_beat(d, r, id, l);
      checks++;
      if ({d, id, r} !== {32'h11111111, 4'd4, 2'b00}) begin
         failures++; $display("FAIL conc_diff_r got=%h %h %b exp=11111111 4 00", d, id, r);
      end
      b_get(id, r);
      checks++;
      if ({id, r} !== {4'd6, 2'b00}) begin failures++; $display("FAIL conc_diff_b got=%h/%b exp=6/00", id, r); end
      rd1(32'h70, d, r);
      checks++;
      if (d !== 32'h77777777) begin failures++; $display("FAIL conc_diff_mem got=%h exp=77777777", d); end

      wr1(32'h80, 32'hAAAA0000, 4'hF, r);
      arid = 4'd0; araddr = 32'h80;
      awid = 4'd7; awaddr = 32'h80;
      arvalid = 1'b1; awvalid = 1'b1;
      tick();
      arvalid = 1'b0; awvalid = 1'b0;
      w_beat(32'hBBBB1111, 4'hF, 1'b1, 4'd7);
      rd_beat(d, r, id, l);
      checks++;
      if (d !== 32'hAAAA0000) begin failures++; $display("FAIL conc_same_old got=%h exp=aaaa0000", d); end
      b_get(id, r);
      rd1(32'h80, d, r);
      checks++;
      if (d !== 32'hBBBB1111) begin failures++; $display("FAIL conc_same_new got=%h exp=bbbb1111", d); end
   endtask

   task automatic test_reset_mid_burst();
      logic [ID_W-1:0] id;
      logic [1:0] r;
      logic [31:0] d;
      logic l;
      int n = 0;
      ar_send(4'd0, 32'h20, 8'd3, 3'd2, 2'b01);
      rd_beat(d, r, id, l);
      while (!rvalid && n < TMO) begin tick(); n++; end
      aresetn = 1'b0;
      tick();
      checks++;
      if ({rvalid, arready, rlast} !== 3'b010) begin
         failures++; $display("FAIL rst_mid got=%b exp=010", {rvalid, arready, rlast});
      end
      aresetn = 1'b1;
      tick();
      rd1(32'h2C, d, r);
      checks++;
      if ({d, r} !== {32'd4, 2'b00}) begin failures++; $display("FAIL rst_mid_reread got=%h %b exp=4 00", d, r); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_strobes();
      test_incr_burst();
      test_errors();
      test_concurrent();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder (slave) fronting an on-chip word-addressed memory array.
- Consumes the AR/R/AW/W/B channels driven by the CPU's SRAM-to-AXI master bridge, and serves as the bench and FPGA memory model.
- Read and write paths are independent FSMs, each with one outstanding transaction.
- Supports INCR/FIXED bursts of up to 16 beats and byte strobes.

Parameters:
ADDR_W, 16, byte-address bits decoded; the array holds 2^(ADDR_W-2) 32-bit words.
ID_W, 4, width of all ID fields.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous, active-low reset
arid  in  ID_W  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1
arsize  in  3  bytes/beat = 2^arsize
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_W  echoed arid
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final read beat
rvalid  out  1  R valid
rready  in  1  R ready
awid/awaddr/awlen/awsize/awburst  in  ID_W/32/8/3/2  write address, same encodings as AR
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  ID_W  write-data ID
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  final write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_W  echoed awid
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset: clock aclk, synchronous active-low aresetn. Both FSMs go to IDLE.
  - Reset output values: arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rlast=0; rdata, rid, rresp, bid, bresp all 0.
  - Reset mid-burst abandons the transaction without completing it. Array contents are not reset.
- Read FSM, R_IDLE -> R_ACC -> R_DATA:
  - arready=1 only in R_IDLE. On arvalid&&arready, latch id/addr/len/size/burst, clear the beat counter, go to R_ACC.
  - R_ACC: read the array at addr[ADDR_W-1:2] into rdata, go to R_DATA.
  - R_DATA: rvalid=1; rlast=1 iff beat==len. rdata/rid/rresp are held stable while rvalid && !rready.
  - On rvalid&&rready: if last, go to R_IDLE; else advance addr, increment beat, go to R_ACC.
  - Latency: AR handshake at cycle T gives first rvalid at T+2. Each later beat arrives 2 cycles after the previous handshake.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - awready=1 only in W_IDLE. On handshake, latch fields, clear the beat counter and error flag, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready writes the bytes enabled by wstrb to addr[ADDR_W-1:2] at that clock edge, then advances addr and beat. After the beat==len handshake, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched awid, bresp=OKAY, or SLVERR if the error flag is set. On bready, go to W_IDLE.
  - The W channel is never accepted before the AW handshake.
- Address advance:
  - INCR and WRAP: addr += 2^size. WRAP is treated as INCR; no wrap boundary is applied.
  - FIXED: addr unchanged.
  - Carries above ADDR_W bits are tracked in the full 32-bit addr.
- Error (SLVERR) conditions, evaluated per beat:
  - size>2
  - burst==11
  - addr[31:ADDR_W]!=0
  - On writes only: wid!=awid, or wlast!=(beat==len).
- Error effects:
  - An errored read beat returns rdata=0 with rresp=SLVERR. The burst still completes with len+1 beats.
  - An errored write beat performs no array write and sets the sticky error flag. The burst length is still governed by awlen.
- Narrow transfers: rdata is always the full aligned word. Writes rely on wstrb; no lane steering is performed.
- Read and write paths operate concurrently. If an R_ACC read and a write beat hit the same word in the same cycle, the read returns the pre-write data.

Test Plan:
- Reset, then single write: AW id=1, addr=0x10, len=0, size=2; W data=0xDEADBEEF, strb=F, wlast=1 -> bvalid with bid=1, bresp=00. Then AR id=0, addr=0x10 -> rvalid at T+2 with rdata=0xDEADBEEF, rid=0, rlast=1, rresp=00.
- Byte strobes: write 0x11223344 with strb=0101 over a word of 0 -> readback 0x00220044.
- INCR read burst: addr=0x20, len=3 over preloaded words 1..4 -> 4 beats returning 1,2,3,4, rlast only on beat 4. Hold rready=0 for 3 cycles on beat 2 -> rdata stays 2 and rvalid stays 1.
- Errors: araddr=0x00010000 with ADDR_W=16 -> rdata=0, rresp=10. Write with wlast=1 on beat 0 of len=1 -> bresp=10. Write with arburst/awburst=11 -> bresp=10 and memory unchanged.
- Concurrency: AR and AW handshake in the same cycle to different addresses -> both complete with correct data. Same word in the same cycle -> old data is read.
- Reset asserted during beat 2 of a len=3 read -> rvalid=0 and arready=1 the next cycle. A new read then succeeds.
